// File: rtl/spw_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spw_rx_fifo_ctrl
// Purpose  : Pointer, occupancy and flow-control-credit controller for the
//            SpaceWire receive FIFO. It drives the write and read addresses of
//            an external 2**AWIDTH x 9-bit storage array. It also tracks the
//            credit granted to the link partner and requests an FCT whenever
//            another FCT_CHARS N-chars of space can be granted.
// Ports    : i_clock      system clock, rising edge
//            i_reset      synchronous active-low reset
//            i_link_run   link FSM in Run; low clears credit
//            i_wr_en      receiver delivers one N-char
//            i_rd_en      consumer pops one N-char
//            i_fct_ack    transmitter sent one FCT (valid while o_fct_req=1)
//            o_wr_ptr     storage write address
//            o_rd_ptr     storage read address
//            o_empty      no valid entries
//            o_full       count == 2**AWIDTH-1
//            o_count      number of valid entries
//            o_credit_cnt N-chars the partner may still send
//            o_fct_req    request one FCT transmission
//            o_credit_err sticky credit / overflow error
// Revision : 1.0 - initial release
// ============================================================================
module spw_rx_fifo_ctrl #(
    parameter int AWIDTH     = 6,
    parameter int FCT_CHARS  = 8,
    parameter int MAX_CREDIT = 56
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_link_run,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic              i_fct_ack,
    output logic [AWIDTH-1:0] o_wr_ptr,
    output logic [AWIDTH-1:0] o_rd_ptr,
    output logic              o_empty,
    output logic              o_full,
    output logic [AWIDTH:0]   o_count,
    output logic [6:0]        o_credit_cnt,
    output logic              o_fct_req,
    output logic              o_credit_err
);

    // The storage writes at wr_ptr on every clock, so one slot always stays
    // free: the FIFO is full at 2**AWIDTH-1 entries.
    localparam int               c_USABLE       = (2 ** AWIDTH) - 1;
    localparam logic [AWIDTH:0]  c_FULL_CNT     = (AWIDTH+1)'(c_USABLE);
    // Grant another FCT only if count+credit leaves FCT_CHARS free slots and
    // the credit would not exceed MAX_CREDIT.
    localparam logic [AWIDTH+1:0] c_USED_LIMIT  = (AWIDTH+2)'(c_USABLE - FCT_CHARS);
    localparam logic [6:0]       c_CREDIT_LIMIT = 7'(MAX_CREDIT - FCT_CHARS);
    localparam logic [6:0]       c_FCT_INC      = 7'(FCT_CHARS);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic [6:0]        r_credit;
    logic              r_fct_req;
    logic              r_credit_err;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ack_acc;
    logic              w_credit_dec;
    logic              w_err_set;
    logic              w_grant_ok;
    logic [AWIDTH:0]   w_count_nxt;
    logic [AWIDTH+1:0] w_used;
    logic [6:0]        w_credit_nxt;
    logic              w_fct_req_nxt;

    // A full FIFO drops the write; an empty FIFO ignores the read.
    assign w_wr_acc  = i_wr_en & ~r_full;
    assign w_rd_acc  = i_rd_en & ~r_empty;
    assign w_ack_acc = i_fct_ack & r_fct_req;

    // Credit never underflows: a write with zero credit is flagged instead.
    assign w_credit_dec = i_wr_en & (r_credit != 7'd0);
    assign w_err_set    = i_wr_en & (r_full | (r_credit == 7'd0));

    assign w_count_nxt = r_count + {{AWIDTH{1'b0}}, w_wr_acc}
                                 - {{AWIDTH{1'b0}}, w_rd_acc};

    // Space already spoken for: stored entries plus outstanding credit.
    assign w_used = {1'b0, r_count} + {{(AWIDTH+2-7){1'b0}}, r_credit};

    assign w_grant_ok = i_link_run
                      & (w_used <= c_USED_LIMIT)
                      & (r_credit <= c_CREDIT_LIMIT);

    always_comb begin
        w_credit_nxt = 7'd0;
        if (i_link_run) begin
            w_credit_nxt = r_credit
                         + (w_ack_acc ? c_FCT_INC : 7'd0)
                         - {6'd0, w_credit_dec};
        end
    end

    // An accepted ack always drops the request for at least one cycle.
    always_comb begin
        w_fct_req_nxt = w_grant_ok;
        if (w_ack_acc) begin
            w_fct_req_nxt = 1'b0;
        end else if (!i_link_run) begin
            w_fct_req_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_credit     <= 7'd0;
            r_fct_req    <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count   <= w_count_nxt;
            r_empty   <= (w_count_nxt == '0);
            r_full    <= (w_count_nxt == c_FULL_CNT);
            r_credit  <= w_credit_nxt;
            r_fct_req <= w_fct_req_nxt;
            if (w_err_set) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign o_wr_ptr     = r_wr_ptr;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_empty      = r_empty;
    assign o_full       = r_full;
    assign o_count      = r_count;
    assign o_credit_cnt = r_credit;
    assign o_fct_req    = r_fct_req;
    assign o_credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_spw_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spw_rx_fifo_ctrl
// Purpose  : Self-checking bench for spw_rx_fifo_ctrl. A vector table covers
//            reset and the FCT credit ramp. Hand-written sequences cover
//            fill, overflow, wrap, simultaneous access and link drop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spw_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_link_run = 1'b0;
    logic       i_wr_en = 1'b0;
    logic       i_rd_en = 1'b0;
    logic       i_fct_ack = 1'b0;
    logic [5:0] o_wr_ptr;
    logic [5:0] o_rd_ptr;
    logic       o_empty;
    logic       o_full;
    logic [6:0] o_count;
    logic [6:0] o_credit_cnt;
    logic       o_fct_req;
    logic       o_credit_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spw_rx_fifo_ctrl #(
        .AWIDTH     (6),
        .FCT_CHARS  (8),
        .MAX_CREDIT (56)
    ) u_dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_link_run   (i_link_run),
        .i_wr_en      (i_wr_en),
        .i_rd_en      (i_rd_en),
        .i_fct_ack    (i_fct_ack),
        .o_wr_ptr     (o_wr_ptr),
        .o_rd_ptr     (o_rd_ptr),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_count      (o_count),
        .o_credit_cnt (o_credit_cnt),
        .o_fct_req    (o_fct_req),
        .o_credit_err (o_credit_err)
    );

    typedef struct {
        string name;
        logic  rst_n, run, wr, rd, ack;
        int    e_wr, e_rd, e_cnt, e_empty, e_full, e_credit, e_req, e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input int ewr, input int erd,
                             input int ecnt, input int eempty, input int efull,
                             input int ecredit, input int ereq, input int eerr);
        chk({nm, ".wr_ptr"},     int'(o_wr_ptr),     ewr);
        chk({nm, ".rd_ptr"},     int'(o_rd_ptr),     erd);
        chk({nm, ".count"},      int'(o_count),      ecnt);
        chk({nm, ".empty"},      int'(o_empty),      eempty);
        chk({nm, ".full"},       int'(o_full),       efull);
        chk({nm, ".credit"},     int'(o_credit_cnt), ecredit);
        chk({nm, ".fct_req"},    int'(o_fct_req),    ereq);
        chk({nm, ".credit_err"}, int'(o_credit_err), eerr);
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic rst_n, input logic run, input logic wr,
                         input logic rd, input logic ack);
        i_reset    = rst_n;
        i_link_run = run;
        i_wr_en    = wr;
        i_rd_en    = rd;
        i_fct_ack  = ack;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic rst_n,
                                input logic run, input logic wr, input logic rd,
                                input logic ack, input int ecredit, input int ereq);
        vec_t v;
        v.name = nm; v.rst_n = rst_n; v.run = run; v.wr = wr; v.rd = rd; v.ack = ack;
        v.e_wr = 0; v.e_rd = 0; v.e_cnt = 0; v.e_empty = 1; v.e_full = 0;
        v.e_credit = ecredit; v.e_req = ereq; v.e_err = 0;
        return v;
    endfunction

    initial begin
        // ---------------- table: reset and FCT ramp on an empty FIFO --------
        tbl.push_back(mk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
        tbl.push_back(mk("ack_no_req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
        for (int k = 0; k < 7; k++) begin
            tbl.push_back(mk($sformatf("ramp_req%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8*k, 1));
            tbl.push_back(mk($sformatf("ramp_ack%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8*k+8, 0));
        end
        tbl.push_back(mk("no_8th_fct", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 56, 0));
        tbl.push_back(mk("stray_ack",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 56, 0));
        tbl.push_back(mk("steady56",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 56, 0));

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].run, tbl[i].wr, tbl[i].rd, tbl[i].ack);
            check_all(tbl[i].name, tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_cnt,
                      tbl[i].e_empty, tbl[i].e_full, tbl[i].e_credit,
                      tbl[i].e_req, tbl[i].e_err);
        end

        // ---------------- 56 credited writes --------------------------------
        for (int i = 1; i <= 56; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check_all($sformatf("fill%0d", i), i, 0, i, 0, 0, 56 - i, 0, 0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("idle56", 56, 0, 56, 0, 0, 0, 0, 0);

        // ---------------- uncredited writes up to full, then overflow -------
        for (int i = 57; i <= 63; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check_all($sformatf("fill%0d", i), i, 0, i, 0, (i == 63) ? 1 : 0, 0, 0, 1);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_all("overflow", 63, 0, 63, 0, 1, 0, 0, 1);

        // ---------------- full with wr&rd: read wins, then drain ------------
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_all("full_wr_rd", 63, 1, 62, 0, 0, 0, 0, 1);
        for (int i = 2; i <= 63; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            // request follows the count seen before this edge (64-i)
            check_all($sformatf("drain%0d", i), 63, i, 63 - i, (i == 63) ? 1 : 0, 0, 0,
                      ((64 - i) <= 55) ? 1 : 0, 1);
        end

        // ---------------- empty with wr&rd, then count=1 with wr&rd ---------
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_all("empty_wr_rd", 0, 63, 1, 0, 0, 0, 1, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_all("one_wr_rd", 1, 0, 1, 0, 0, 0, 1, 1);

        // ---------------- link drop with credit 24 --------------------------
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("reset2", 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            check_all($sformatf("r2_req%0d", k), 0, 0, 0, 1, 0, 8*k, 1, 0);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            check_all($sformatf("r2_ack%0d", k), 0, 0, 0, 1, 0, 8*k+8, 0, 0);
        end
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check_all($sformatf("r2_wr%0d", i), i, 0, i, 0, 0, 32 - i, 1, 0);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            check_all($sformatf("r2_rd%0d", i), 8, i, 8 - i, 0, 0, 24, 1, 0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("link_drop", 8, 3, 5, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_all("wr_no_credit", 9, 3, 6, 0, 0, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
